// File: rtl/seg_display_capture_if.sv
// Multiplexed seven-segment display bus: segment lines plus digit selects.
// The display driver is the master and the capture monitor is the slave.
interface seg_display_capture_if;
  logic [0:6] seg;    // seg[0]=a ... seg[6]=g
  logic [1:0] anode;  // anode[0]=digit0, anode[1]=digit1

  modport master (output seg, output anode);
  modport slave  (input  seg, input  anode);
endinterface

// File: rtl/seg_display_capture.sv
// Reads back a 2-digit multiplexed seven-segment display: waits for a stable pattern,
// decodes it to a hex nibble per digit and flags illegal glyphs.
module seg_display_capture #(
  parameter int STABLE_CYCLES  = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk_in,
  input  logic                  rst,
  seg_display_capture_if.slave  disp,
  input  logic                  clr_err,
  output logic [3:0]            digit0,
  output logic [3:0]            digit1,
  output logic [1:0]            valid,
  output logic                  update,
  output logic                  upd_idx,
  output logic                  bad_pattern
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);

  typedef struct packed {
    logic [1:0] anode;
    logic [0:6] seg;
  } smp_t;

  // Returns {legal, nibble}; blank and unknown patterns both come back not-legal.
  function automatic logic [4:0] decode(input logic [0:6] p);
    logic [4:0] r;
    r = 5'h00;
    case (p)
      7'b1111110: r = {1'b1, 4'h0};
      7'b0110000: r = {1'b1, 4'h1};
      7'b1101101: r = {1'b1, 4'h2};
      7'b1111001: r = {1'b1, 4'h3};
      7'b0110011: r = {1'b1, 4'h4};
      7'b1011011: r = {1'b1, 4'h5};
      7'b1011111: r = {1'b1, 4'h6};
      7'b1110000: r = {1'b1, 4'h7};
      7'b1111111: r = {1'b1, 4'h8};
      7'b1111011: r = {1'b1, 4'h9};
      7'b1110111: r = {1'b1, 4'hA};
      7'b0011111: r = {1'b1, 4'hB};
      7'b1001110: r = {1'b1, 4'hC};
      7'b0111101: r = {1'b1, 4'hD};
      7'b1001111: r = {1'b1, 4'hE};
      7'b1000111: r = {1'b1, 4'hF};
      default:    r = 5'h00;
    endcase
    return r;
  endfunction

  smp_t       smp_q, smp_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] digit0_q, digit0_d;
  logic [3:0] digit1_q, digit1_d;
  logic [1:0] valid_q, valid_d;
  logic       update_q, update_d;
  logic       upd_idx_q, upd_idx_d;
  logic       bad_q, bad_d;

  logic       one_hot;
  logic       stable;
  logic       capture;
  logic       idx;
  logic [4:0] dec;

  // NOTE: every signal assigned here gets a default first, so no path leaves a latch.
  always_comb begin
    smp_d.anode = AN_ACTIVE_LOW  ? ~disp.anode : disp.anode;
    smp_d.seg   = SEG_ACTIVE_LOW ? ~disp.seg   : disp.seg;

    one_hot = (smp_d.anode == 2'b01) || (smp_d.anode == 2'b10);
    stable  = (smp_d == smp_q);
    idx     = smp_d.anode[1];
    dec     = decode(smp_d.seg);

    if (!stable || !one_hot) begin
      cnt_d = one_hot ? 8'd1 : 8'd0;
    end else if (cnt_q < CNT_MAX) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end

    // Fires only on the step into saturation, so once per stable window.
    capture = stable && one_hot && (cnt_q == CNT_MAX - 8'd1);

    digit0_d  = digit0_q;
    digit1_d  = digit1_q;
    valid_d   = valid_q;
    update_d  = 1'b0;
    upd_idx_d = upd_idx_q;
    bad_d     = clr_err ? 1'b0 : bad_q;

    if (capture) begin
      if (dec[4]) begin
        if (idx) digit1_d = dec[3:0];
        else     digit0_d = dec[3:0];
        valid_d[idx] = 1'b1;
        update_d     = 1'b1;
        upd_idx_d    = idx;
      end else if (smp_d.seg == 7'b0000000) begin
        valid_d[idx] = 1'b0;
        update_d     = 1'b1;
        upd_idx_d    = idx;
      end else begin
        bad_d = 1'b1;  // set overrides a same-cycle clear
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      smp_q     <= '0;
      cnt_q     <= 8'd0;
      digit0_q  <= 4'h0;
      digit1_q  <= 4'h0;
      valid_q   <= 2'b00;
      update_q  <= 1'b0;
      upd_idx_q <= 1'b0;
      bad_q     <= 1'b0;
    end else begin
      smp_q     <= smp_d;
      cnt_q     <= cnt_d;
      digit0_q  <= digit0_d;
      digit1_q  <= digit1_d;
      valid_q   <= valid_d;
      update_q  <= update_d;
      upd_idx_q <= upd_idx_d;
      bad_q     <= bad_d;
    end
  end

  assign digit0      = digit0_q;
  assign digit1      = digit1_q;
  assign valid       = valid_q;
  assign update      = update_q;
  assign upd_idx     = upd_idx_q;
  assign bad_pattern = bad_q;

endmodule

// File: tb/tb_seg_display_capture.sv
// Directed bench for seg_display_capture with default parameters (4-sample window,
// active-low segments and anodes).
module tb_seg_display_capture;

  logic       clk_in = 1'b0;
  logic       rst;
  logic       clr_err;
  logic [3:0] digit0, digit1;
  logic [1:0] valid;
  logic       update, upd_idx, bad_pattern;

  int checks    = 0;
  int failures  = 0;
  int upd_count = 0;
  int base;

  seg_display_capture_if disp ();

  seg_display_capture dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .disp        (disp.slave),
    .clr_err     (clr_err),
    .digit0      (digit0),
    .digit1      (digit1),
    .valid       (valid),
    .update      (update),
    .upd_idx     (upd_idx),
    .bad_pattern (bad_pattern)
  );

  always #5 clk_in = ~clk_in;

  // update is a one-cycle pulse, so sampling on the falling edge sees each pulse once.
  always @(negedge clk_in) if (update === 1'b1) upd_count++;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic drive(input logic [1:0] an, input logic [0:6] sg);
    disp.anode = an;
    disp.seg   = sg;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst     = 1'b1;
    clr_err = 1'b0;
    drive(2'b11, 7'b1111111);
    step(2);
    check("rst_digit0", 32'(digit0), 32'h0);
    check("rst_digit1", 32'(digit1), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_update", 32'(update), 32'h0);
    check("rst_bad", 32'(bad_pattern), 32'h0);
    #2 rst = 1'b0;
    step(1);

    // "3" on digit0: capture on the 4th edge, exactly one pulse.
    base = upd_count;
    drive(2'b10, 7'b0000110);
    step(3);
    check("d3_early_valid", 32'(valid), 32'h0);
    check("d3_early_update", 32'(update), 32'h0);
    step(1);
    check("d3_update", 32'(update), 32'h1);
    check("d3_upd_idx", 32'(upd_idx), 32'h0);
    check("d3_digit0", 32'(digit0), 32'h3);
    check("d3_valid", 32'(valid), 32'h1);
    step(6);
    check("d3_one_pulse", 32'(upd_count - base), 32'd1);
    check("d3_update_low", 32'(update), 32'h0);

    // "A" on digit1.
    base = upd_count;
    drive(2'b01, 7'b0001000);
    step(3);
    check("dA_early_digit1", 32'(digit1), 32'h0);
    step(1);
    check("dA_update", 32'(update), 32'h1);
    check("dA_upd_idx", 32'(upd_idx), 32'h1);
    check("dA_digit1", 32'(digit1), 32'hA);
    check("dA_valid", 32'(valid), 32'h3);
    check("dA_digit0", 32'(digit0), 32'h3);
    step(4);
    check("dA_one_pulse", 32'(upd_count - base), 32'd1);

    // Pattern toggling every 2 cycles never stabilises; both anodes selected never captures.
    base = upd_count;
    for (int i = 0; i < 6; i++) begin
      drive(2'b10, (i % 2 == 0) ? 7'b0000110 : 7'b0000000);
      step(2);
    end
    drive(2'b00, 7'b0000000);
    step(10);
    check("unstable_no_update", 32'(upd_count - base), 32'd0);
    check("unstable_digit0", 32'(digit0), 32'h3);
    check("unstable_digit1", 32'(digit1), 32'hA);
    check("unstable_valid", 32'(valid), 32'h3);

    // Illegal "-" on digit0 sets the sticky flag; clr_err clears it.
    base = upd_count;
    drive(2'b10, 7'b1111110);
    step(6);
    check("bad_set", 32'(bad_pattern), 32'h1);
    check("bad_valid", 32'(valid), 32'h3);
    check("bad_digit0", 32'(digit0), 32'h3);
    check("bad_no_update", 32'(upd_count - base), 32'd0);
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
    check("bad_cleared", 32'(bad_pattern), 32'h0);
    step(2);
    check("bad_stays_clear", 32'(bad_pattern), 32'h0);

    // Set wins over a clear on the same edge.
    drive(2'b01, 7'b1111110);
    step(3);
    clr_err = 1'b1;
    step(1);
    check("bad_set_wins", 32'(bad_pattern), 32'h1);
    step(1);
    clr_err = 1'b0;
    check("bad_clr_after", 32'(bad_pattern), 32'h0);

    // Blank on digit0: pulse, valid[0] drops, digit0 held, no error.
    base = upd_count;
    drive(2'b10, 7'b1111111);
    step(4);
    check("blank_update", 32'(update), 32'h1);
    check("blank_upd_idx", 32'(upd_idx), 32'h0);
    check("blank_valid", 32'(valid), 32'h2);
    check("blank_digit0", 32'(digit0), 32'h3);
    step(2);
    check("blank_bad", 32'(bad_pattern), 32'h0);
    check("blank_one_pulse", 32'(upd_count - base), 32'd1);

    // Reset two edges into a "5" window, then a full new window.
    drive(2'b10, 7'b0100100);
    step(2);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_digit0", 32'(digit0), 32'h0);
    check("mid_rst_digit1", 32'(digit1), 32'h0);
    check("mid_rst_valid", 32'(valid), 32'h0);
    check("mid_rst_update", 32'(update), 32'h0);
    #2 rst = 1'b0;
    step(3);
    check("d5_early_valid", 32'(valid), 32'h0);
    check("d5_early_digit0", 32'(digit0), 32'h0);
    step(1);
    check("d5_update", 32'(update), 32'h1);
    check("d5_digit0", 32'(digit0), 32'h5);
    check("d5_valid", 32'(valid), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_display_capture.md
Name: seg_display_capture

Overview:
- Reader side of the multiplexed 2-digit seven-segment interface produced by the display driver.
- Samples the `seg`/`anode` lines, waits until each digit pattern has been stable for a set time, decodes it back to a hex nibble, and holds per-digit values.
- Flags patterns that do not match a legal glyph.
- Used in self-checking benches and as an on-chip readback monitor for the display path.

Parameters:
- STABLE_CYCLES, 4: consecutive identical samples required before a capture; legal range 2..255.
- SEG_ACTIVE_LOW, 1: 1 = a segment is lit when its bit is 0.
- AN_ACTIVE_LOW, 1: 1 = a digit is selected when its anode bit is 0.

Ports:
- clk_in  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset; asynchronous, active-high.
- seg  in  [0:6]  segment lines; seg[0]=a … seg[6]=g.
- anode  in  [1:0]  digit selects; anode[0]=digit0, anode[1]=digit1.
- clr_err  in  1  synchronous clear of bad_pattern.
- digit0  out  [3:0]  last captured nibble, digit0.
- digit1  out  [3:0]  last captured nibble, digit1.
- valid  out  [1:0]  per-digit flag: a legal glyph is currently held.
- update  out  1  one-cycle pulse on each capture, including blank captures.
- upd_idx  out  1  digit index of the current update pulse.
- bad_pattern  out  1  sticky illegal-glyph flag.

Behaviour:
- Reset (async, while rst=1):
  - digit0=0, digit1=0, valid=00, update=0, upd_idx=0, bad_pattern=0.
  - Sample register = all-inactive (anode inactive, seg unlit); counter=0.
- Normalisation: seg and anode are converted to active-high using the parameters. All rules below use active-high values.
- Sampling: each edge registers {anode,seg} into smp.
  - If the new sample differs from smp, or the digit selection is not one-hot, the counter is set to 1 (0 if not one-hot).
  - Otherwise the counter increments, saturating at STABLE_CYCLES.
- Capture: occurs on the edge where the counter goes STABLE_CYCLES-1 → STABLE_CYCLES; exactly once per stable window.
  - Latency: input applied before edge e0 and held → outputs change after edge e0+STABLE_CYCLES-1 (STABLE_CYCLES edges of sampling).
  - No further capture occurs until the sample changes.
- Selection rules:
  - anode none selected or both selected → no capture, counter held at 0.
  - No outputs change in this case.
- Decode table (active-high abcdefg):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111
- Capture outcomes:
  - Legal glyph: digitN=nibble, valid[N]=1, update=1, upd_idx=N.
  - Blank (0000000): valid[N]=0, digitN unchanged, update=1, upd_idx=N, no error.
  - Any other pattern: bad_pattern=1; digitN/valid[N] unchanged; no update pulse.
- bad_pattern:
  - Stays 1 until clr_err=1 or reset.
  - If clr_err and a new illegal capture occur on the same edge, bad_pattern=1 (set wins).
- update: high for exactly one cycle per capture; 0 otherwise.
- Reset mid-window: all state clears immediately; after release, capture requires a full new stable window.

Test Plan:
- anode=10, seg=0000110 (raw, "3"), held 10 cycles → after 4th edge digit0=3, valid=01, one update pulse, upd_idx=0; no second pulse.
- Then anode=01, seg=0001000 (raw, "A"), held 8 cycles → digit1=A, valid=11, digit0 still 3, update once with upd_idx=1.
- Raw seg toggles between "3" and "8" every 2 cycles on anode=10 → no update, digits unchanged; anode=00 held 10 cycles → no capture.
- anode=10, raw seg=1111110 (active-high 0000001, "-"), held 6 cycles → bad_pattern=1, valid/digit0 unchanged, update never asserts; pulse clr_err → bad_pattern=0.
- anode=10, raw seg=1111111 (blank), held 6 cycles → valid[0]=0, digit0 unchanged, update pulse, bad_pattern stays 0.
- During capture of "5", assert rst asynchronously after edge 2 → all outputs 0 immediately; release and hold "5" → capture after a full 4-edge window, digit0=5.
